// File: rtl/usb3_tx_arbiter.sv
// USB3 link-layer TX arbiter: grants link commands ahead of round-robin header/data
// packets, feeds one registered word per cycle to the scrambler, and pads each packet with idle words.
module usb3_tx_arbiter #(
    parameter int MAX_WORDS  = 263,
    parameter int GAP_CYCLES = 1
) (
    input  logic        local_clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        lc_req,
    input  logic        hp_req,
    input  logic        dp_req,
    input  logic [31:0] lc_data,
    input  logic [31:0] hp_data,
    input  logic [31:0] dp_data,
    input  logic [3:0]  lc_datak,
    input  logic [3:0]  hp_datak,
    input  logic [3:0]  dp_datak,
    input  logic        lc_last,
    input  logic        hp_last,
    input  logic        dp_last,
    output logic        lc_ack,
    output logic        hp_ack,
    output logic        dp_ack,
    input  logic        raw_stall,
    output logic [31:0] raw_data,
    output logic [3:0]  raw_datak,
    output logic        raw_active,
    output logic        err_timeout,
    output logic        err_underrun
);

    // state | meaning
    // IDLE  | no owner, arbitrate when enabled and not stalled
    // LC    | link command owns the link
    // HP    | header packet owns the link
    // DP    | data payload owns the link
    // GAP   | inter-packet idle words, then back to IDLE
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LC   = 3'd1;
    localparam logic [2:0] S_HP   = 3'd2;
    localparam logic [2:0] S_DP   = 3'd3;
    localparam logic [2:0] S_GAP  = 3'd4;

    localparam logic [8:0] MAX_W = 9'(MAX_WORDS);
    localparam logic [3:0] GAP_W = 4'(GAP_CYCLES);

    logic [2:0]  state;
    logic [8:0]  word_cnt;
    logic [3:0]  gap_cnt;
    logic        rr_hp;
    logic        cur_req;
    logic        cur_last;
    logic [31:0] cur_data;
    logic [3:0]  cur_datak;
    logic        owner_state;
    logic        can_ack;
    logic [8:0]  word_cnt_nxt;

    assign owner_state  = (state == S_LC) || (state == S_HP) || (state == S_DP);
    assign can_ack      = reset_n & enable & ~raw_stall;
    assign word_cnt_nxt = word_cnt + 9'd1;

    always_comb begin
        cur_req   = 1'b0;
        cur_last  = 1'b0;
        cur_data  = 32'd0;
        cur_datak = 4'd0;
        case (state)
            S_LC: begin
                cur_req = lc_req; cur_last = lc_last; cur_data = lc_data; cur_datak = lc_datak;
            end
            S_HP: begin
                cur_req = hp_req; cur_last = hp_last; cur_data = hp_data; cur_datak = hp_datak;
            end
            S_DP: begin
                cur_req = dp_req; cur_last = dp_last; cur_data = dp_data; cur_datak = dp_datak;
            end
            default: ;
        endcase
    end

    assign lc_ack = can_ack & (state == S_LC) & lc_req;
    assign hp_ack = can_ack & (state == S_HP) & hp_req;
    assign dp_ack = can_ack & (state == S_DP) & dp_req;

    always_ff @(posedge local_clk) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            word_cnt     <= 9'd0;
            gap_cnt      <= 4'd0;
            rr_hp        <= 1'b1;
            raw_data     <= 32'd0;
            raw_datak    <= 4'd0;
            raw_active   <= 1'b0;
            err_timeout  <= 1'b0;
            err_underrun <= 1'b0;
        end else begin
            err_timeout  <= 1'b0;
            err_underrun <= 1'b0;
            // back-pressure freezes everything, including a pending enable abort
            if (!raw_stall) begin
                raw_data   <= 32'd0;
                raw_datak  <= 4'd0;
                raw_active <= 1'b0;
                if (state == S_IDLE) begin
                    if (enable) begin
                        if (lc_req) begin
                            state    <= S_LC;
                            word_cnt <= 9'd0;
                        end else if (hp_req && (rr_hp || !dp_req)) begin
                            state    <= S_HP;
                            word_cnt <= 9'd0;
                            rr_hp    <= 1'b0;
                        end else if (dp_req) begin
                            state    <= S_DP;
                            word_cnt <= 9'd0;
                            rr_hp    <= 1'b1;
                        end
                    end
                end else if (owner_state) begin
                    if (!enable) begin
                        state   <= S_GAP;
                        gap_cnt <= GAP_W;
                    end else if (cur_req) begin
                        raw_data   <= cur_data;
                        raw_datak  <= cur_datak;
                        raw_active <= 1'b1;
                        word_cnt   <= word_cnt_nxt;
                        if (cur_last || (word_cnt_nxt == MAX_W)) begin
                            state       <= S_GAP;
                            gap_cnt     <= GAP_W;
                            err_timeout <= ~cur_last;
                        end
                    end else begin
                        err_underrun <= 1'b1;
                    end
                end else begin
                    if (gap_cnt <= 4'd1) begin
                        state   <= S_IDLE;
                        gap_cnt <= 4'd0;
                    end else begin
                        gap_cnt <= gap_cnt - 4'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_usb3_tx_arbiter.sv
// Directed self-checking bench for usb3_tx_arbiter with default parameters.
module tb_usb3_tx_arbiter;

    logic        local_clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic        lc_req, hp_req, dp_req;
    logic [31:0] lc_data, hp_data, dp_data;
    logic [3:0]  lc_datak, hp_datak, dp_datak;
    logic        lc_last, hp_last, dp_last;
    logic        lc_ack, hp_ack, dp_ack;
    logic        raw_stall;
    logic [31:0] raw_data;
    logic [3:0]  raw_datak;
    logic        raw_active;
    logic        err_timeout;
    logic        err_underrun;

    int checks = 0;
    int errors = 0;

    usb3_tx_arbiter dut (
        .local_clk   (local_clk),
        .reset_n     (reset_n),
        .enable      (enable),
        .lc_req      (lc_req),
        .hp_req      (hp_req),
        .dp_req      (dp_req),
        .lc_data     (lc_data),
        .hp_data     (hp_data),
        .dp_data     (dp_data),
        .lc_datak    (lc_datak),
        .hp_datak    (hp_datak),
        .dp_datak    (dp_datak),
        .lc_last     (lc_last),
        .hp_last     (hp_last),
        .dp_last     (dp_last),
        .lc_ack      (lc_ack),
        .hp_ack      (hp_ack),
        .dp_ack      (dp_ack),
        .raw_stall   (raw_stall),
        .raw_data    (raw_data),
        .raw_datak   (raw_datak),
        .raw_active  (raw_active),
        .err_timeout (err_timeout),
        .err_underrun(err_underrun)
    );

    always #5 local_clk = ~local_clk;

    task automatic tick;
        @(posedge local_clk);
        #1;
    endtask

    task automatic drop_all;
        lc_req = 0; hp_req = 0; dp_req = 0;
        lc_last = 0; hp_last = 0; dp_last = 0;
        tick; tick; tick;
    endtask

    task automatic test_reset;
        reset_n = 0; lc_req = 1; lc_last = 1;
        #1;
        checks++;
        if (lc_ack !== 1'b0) begin
            errors++; $display("FAIL reset_ack_pre got %b want 0", lc_ack);
        end
        tick; tick;
        checks++;
        if (raw_active !== 1'b0 || raw_data !== 32'd0 || raw_datak !== 4'd0) begin
            errors++; $display("FAIL reset_raw got act=%b data=%h k=%h want 0/0/0", raw_active, raw_data, raw_datak);
        end
        checks++;
        if (err_timeout !== 1'b0 || err_underrun !== 1'b0 || lc_ack !== 1'b0) begin
            errors++; $display("FAIL reset_err got to=%b ur=%b ack=%b want 0", err_timeout, err_underrun, lc_ack);
        end
        lc_req = 0; lc_last = 0; reset_n = 1;
        tick;
    endtask

    task automatic test_lc_priority;
        lc_req = 1; hp_req = 1; hp_last = 1; hp_data = 32'hBEEF_0001; hp_datak = 4'h1;
        lc_datak = 4'hF; lc_last = 0; lc_data = 32'h1000_0000;
        #1;
        checks++;
        if (lc_ack !== 1'b0 || hp_ack !== 1'b0) begin
            errors++; $display("FAIL lc_idle_ack got lc=%b hp=%b want 0/0", lc_ack, hp_ack);
        end
        tick;
        for (int i = 0; i < 3; i++) begin
            lc_data = 32'h1000_0000 + 32'(i); lc_last = (i == 2);
            #1;
            checks++;
            if (lc_ack !== 1'b1 || hp_ack !== 1'b0) begin
                errors++; $display("FAIL lc_ack_%0d got lc=%b hp=%b want 1/0", i, lc_ack, hp_ack);
            end
            tick;
            checks++;
            if (raw_data !== 32'h1000_0000 + 32'(i) || raw_datak !== 4'hF || raw_active !== 1'b1) begin
                errors++; $display("FAIL lc_word_%0d got %h/%h/%b want %h/f/1", i, raw_data, raw_datak, raw_active, 32'h1000_0000 + 32'(i));
            end
        end
        lc_req = 0; lc_last = 0;
        #1;
        checks++;
        if (lc_ack !== 1'b0 || hp_ack !== 1'b0) begin
            errors++; $display("FAIL lc_gap_ack got lc=%b hp=%b want 0/0", lc_ack, hp_ack);
        end
        tick;
        checks++;
        if (raw_active !== 1'b0 || raw_data !== 32'd0) begin
            errors++; $display("FAIL lc_gap_idle got act=%b data=%h want 0/0", raw_active, raw_data);
        end
        checks++;
        if (hp_ack !== 1'b0) begin
            errors++; $display("FAIL hp_idle_ack got %b want 0", hp_ack);
        end
        tick;
        checks++;
        if (hp_ack !== 1'b1) begin
            errors++; $display("FAIL hp_after_lc got %b want 1", hp_ack);
        end
        tick;
        checks++;
        if (raw_data !== 32'hBEEF_0001 || raw_datak !== 4'h1) begin
            errors++; $display("FAIL hp_word got %h/%h want beef0001/1", raw_data, raw_datak);
        end
        drop_all;
    endtask

    task automatic test_round_robin;
        reset_n = 0; tick; reset_n = 1;
        hp_req = 1; dp_req = 1; hp_last = 1; dp_last = 1;
        hp_data = 32'hAAAA_0000; dp_data = 32'hDDDD_0000;
        for (int p = 0; p < 4; p++) begin
            #1;
            checks++;
            if (hp_ack !== 1'b0 || dp_ack !== 1'b0) begin
                errors++; $display("FAIL rr_idle_%0d got hp=%b dp=%b want 0/0", p, hp_ack, dp_ack);
            end
            tick;
            checks++;
            if (hp_ack !== (p % 2 == 0) || dp_ack !== (p % 2 == 1)) begin
                errors++; $display("FAIL rr_grant_%0d got hp=%b dp=%b want %b/%b", p, hp_ack, dp_ack, (p % 2 == 0), (p % 2 == 1));
            end
            tick;
            checks++;
            if (raw_data !== ((p % 2 == 0) ? 32'hAAAA_0000 : 32'hDDDD_0000) || raw_active !== 1'b1
                || hp_ack !== 1'b0 || dp_ack !== 1'b0) begin
                errors++; $display("FAIL rr_gap_%0d got data=%h act=%b hp=%b dp=%b", p, raw_data, raw_active, hp_ack, dp_ack);
            end
            tick;
        end
        drop_all;
    endtask

    task automatic test_stall;
        dp_req = 1; dp_last = 0; dp_datak = 4'h0; dp_data = 32'h1111_1111;
        tick;
        #1;
        checks++;
        if (dp_ack !== 1'b1) begin
            errors++; $display("FAIL stall_w1_ack got %b want 1", dp_ack);
        end
        tick;
        dp_data = 32'hA5A5_A5A5;
        #1;
        checks++;
        if (dp_ack !== 1'b1) begin
            errors++; $display("FAIL stall_w2_ack got %b want 1", dp_ack);
        end
        tick;
        dp_data = 32'h2222_2222; raw_stall = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (dp_ack !== 1'b0) begin
                errors++; $display("FAIL stall_ack_%0d got %b want 0", i, dp_ack);
            end
            tick;
            checks++;
            if (raw_data !== 32'hA5A5_A5A5 || raw_active !== 1'b1) begin
                errors++; $display("FAIL stall_hold_%0d got %h/%b want a5a5a5a5/1", i, raw_data, raw_active);
            end
        end
        raw_stall = 0; dp_last = 1;
        #1;
        checks++;
        if (dp_ack !== 1'b1) begin
            errors++; $display("FAIL stall_resume_ack got %b want 1", dp_ack);
        end
        tick;
        checks++;
        if (raw_data !== 32'h2222_2222) begin
            errors++; $display("FAIL stall_resume_word got %h want 22222222", raw_data);
        end
        drop_all;
    endtask

    task automatic test_underrun;
        dp_req = 1; dp_last = 0; dp_data = 32'h3333_3333;
        tick;
        #1;
        checks++;
        if (dp_ack !== 1'b1) begin
            errors++; $display("FAIL ur_first_ack got %b want 1", dp_ack);
        end
        tick;
        dp_req = 0;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (dp_ack !== 1'b0) begin
                errors++; $display("FAIL ur_ack_%0d got %b want 0", i, dp_ack);
            end
            tick;
            checks++;
            if (raw_active !== 1'b0 || raw_data !== 32'd0 || err_underrun !== 1'b1) begin
                errors++; $display("FAIL ur_idle_%0d got act=%b data=%h ur=%b want 0/0/1", i, raw_active, raw_data, err_underrun);
            end
        end
        dp_req = 1; dp_last = 1; dp_data = 32'h4444_4444;
        #1;
        checks++;
        if (dp_ack !== 1'b1) begin
            errors++; $display("FAIL ur_resume_ack got %b want 1", dp_ack);
        end
        tick;
        checks++;
        if (raw_data !== 32'h4444_4444 || raw_active !== 1'b1 || err_underrun !== 1'b0) begin
            errors++; $display("FAIL ur_resume_word got %h/%b ur=%b want 44444444/1/0", raw_data, raw_active, err_underrun);
        end
        drop_all;
    endtask

    task automatic test_timeout;
        hp_req = 1; hp_last = 0;
        tick;
        for (int i = 1; i <= 263; i++) begin
            hp_data = 32'(i);
            #1;
            checks++;
            if (hp_ack !== 1'b1) begin
                errors++; $display("FAIL to_ack_%0d got %b want 1", i, hp_ack);
            end
            tick;
            checks++;
            if (raw_data !== 32'(i) || err_timeout !== (i == 263)) begin
                errors++; $display("FAIL to_word_%0d got %h to=%b want %h/%b", i, raw_data, err_timeout, 32'(i), (i == 263));
            end
        end
        hp_data = 32'd264;
        #1;
        checks++;
        if (hp_ack !== 1'b0) begin
            errors++; $display("FAIL to_w264_ack got %b want 0", hp_ack);
        end
        tick;
        checks++;
        if (raw_active !== 1'b0 || err_timeout !== 1'b0 || hp_ack !== 1'b0) begin
            errors++; $display("FAIL to_idle got act=%b to=%b ack=%b want 0/0/0", raw_active, err_timeout, hp_ack);
        end
        hp_req = 0;
        drop_all;
    endtask

    task automatic test_enable_abort;
        dp_req = 1; dp_last = 0; dp_data = 32'h5555_5555;
        tick;
        tick;
        enable = 0;
        #1;
        checks++;
        if (dp_ack !== 1'b0) begin
            errors++; $display("FAIL en_abort_ack got %b want 0", dp_ack);
        end
        tick;
        checks++;
        if (raw_active !== 1'b0 || dp_ack !== 1'b0) begin
            errors++; $display("FAIL en_gap got act=%b ack=%b want 0/0", raw_active, dp_ack);
        end
        tick;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (dp_ack !== 1'b0 || raw_active !== 1'b0) begin
                errors++; $display("FAIL en_off_%0d got ack=%b act=%b want 0/0", i, dp_ack, raw_active);
            end
            tick;
        end
        enable = 1;
        #1;
        checks++;
        if (dp_ack !== 1'b0) begin
            errors++; $display("FAIL en_idle_ack got %b want 0", dp_ack);
        end
        tick;
        dp_last = 1;
        #1;
        checks++;
        if (dp_ack !== 1'b1) begin
            errors++; $display("FAIL en_regrant got %b want 1", dp_ack);
        end
        tick;
        drop_all;
    endtask

    task automatic test_reset_mid;
        hp_req = 1; hp_last = 0; hp_data = 32'h6666_6666;
        tick;
        tick;
        tick;
        reset_n = 0;
        #1;
        checks++;
        if (hp_ack !== 1'b0) begin
            errors++; $display("FAIL rst_mid_ack got %b want 0", hp_ack);
        end
        tick;
        reset_n = 1;
        checks++;
        if (raw_active !== 1'b0 || raw_data !== 32'd0) begin
            errors++; $display("FAIL rst_mid_raw got act=%b data=%h want 0/0", raw_active, raw_data);
        end
        lc_req = 1; lc_last = 1; lc_data = 32'h7777_7777; lc_datak = 4'h3;
        #1;
        checks++;
        if (hp_ack !== 1'b0 || lc_ack !== 1'b0) begin
            errors++; $display("FAIL rst_mid_idle got hp=%b lc=%b want 0/0", hp_ack, lc_ack);
        end
        tick;
        checks++;
        if (lc_ack !== 1'b1 || hp_ack !== 1'b0) begin
            errors++; $display("FAIL rst_mid_lc got lc=%b hp=%b want 1/0", lc_ack, hp_ack);
        end
        tick;
        checks++;
        if (raw_data !== 32'h7777_7777 || raw_datak !== 4'h3) begin
            errors++; $display("FAIL rst_mid_word got %h/%h want 77777777/3", raw_data, raw_datak);
        end
        drop_all;
    endtask

    initial begin
        reset_n = 0; enable = 1; raw_stall = 0;
        lc_req = 0; hp_req = 0; dp_req = 0;
        lc_data = 0; hp_data = 0; dp_data = 0;
        lc_datak = 0; hp_datak = 0; dp_datak = 0;
        lc_last = 0; hp_last = 0; dp_last = 0;
        test_reset;
        test_lc_priority;
        test_round_robin;
        test_stall;
        test_underrun;
        test_timeout;
        test_enable_abort;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/usb3_tx_arbiter.md
USB3_TX_ARBITER -- requirements
Module: usb3_tx_arbiter

Interface
REQ-001 The block SHALL have parameter MAX_WORDS, default 263, the maximum words per packet before a forced abort.
REQ-002 The block SHALL have parameter GAP_CYCLES, default 1, the number of idle words inserted after every packet (range 1-15).
REQ-003 local_clk  in  1  clock; all logic rising-edge.
REQ-004 reset_n  in  1  reset, synchronous, active-low.
REQ-005 enable  in  1  link TX enabled; when low, no grants are issued and the outputs show idle.
REQ-006 lc_req / hp_req / dp_req  in  1 each  requester has a valid word (link command, header packet, data payload).
REQ-007 lc_data / hp_data / dp_data  in  32 each  requester word.
REQ-008 lc_datak / hp_datak / dp_datak  in  4 each  K-flags per byte.
REQ-009 lc_last / hp_last / dp_last  in  1 each  current word ends the packet.
REQ-010 lc_ack / hp_ack / dp_ack  out  1 each  word consumed this cycle (combinational).
REQ-011 raw_stall  in  1  scrambler back-pressure.
REQ-012 raw_data  out  32  registered word to the scrambler.
REQ-013 raw_datak  out  4  registered K-flags to the scrambler.
REQ-014 raw_active  out  1  registered flag: a packet word is valid (blocks SKP injection).
REQ-015 err_timeout  out  1  one-cycle pulse when a packet exceeds MAX_WORDS.
REQ-016 err_underrun  out  1  one-cycle pulse per cycle that the owner has no word mid-packet.

Function
REQ-017 The block SHALL use states IDLE, LC, HP, DP, GAP.
REQ-018 In IDLE with enable=1 and raw_stall=0, the block SHALL grant in this order: lc_req first; otherwise round-robin between hp and dp. The last-served of hp/dp SHALL lose ties. The round-robin pointer SHALL reset to favour hp.
REQ-019 On a grant, the IDLE->owner transition SHALL take one cycle, and no ack SHALL be issued in the IDLE cycle.
REQ-020 The owner's ack SHALL be (state==owner) & owner_req & ~raw_stall. All other acks SHALL be 0.
REQ-021 On an ack, the next edge SHALL load raw_data/raw_datak from the owner and set raw_active=1 (one-cycle latency).
REQ-022 With raw_stall=1, all raw_* outputs, the state and the word counter SHALL hold.
REQ-023 In the owner state with req=0 and raw_stall=0, the next edge SHALL load raw_data=0, raw_datak=0 and raw_active=0. err_underrun SHALL pulse, and the state SHALL hold.
REQ-024 The owner SHALL keep the link until an acked word has last=1; no preemption, even by lc_req.
REQ-025 An acked last word SHALL move the state to GAP and load the gap counter with GAP_CYCLES.
REQ-026 GAP SHALL output idle words (0/0/active=0) for GAP_CYCLES non-stalled cycles, then go to IDLE.
REQ-027 The 9-bit word counter SHALL clear on entry to an owner state and increment per acked word.
REQ-028 If the counter reaches MAX_WORDS without last, the block SHALL take that word's ack, pulse err_timeout, enter GAP, and treat the word as last.
REQ-029 enable=0 mid-packet SHALL force the state to GAP with no ack that cycle. GAP then completes and the block idles in IDLE.
REQ-030 The block SHALL issue only one ack per cycle.

Reset
REQ-031 On reset_n=0 at an edge, the block SHALL set state=IDLE, raw_data=0, raw_datak=0, raw_active=0, err_*=0, counters=0 and rr pointer=hp. Acks SHALL be 0 while reset_n=0.
REQ-032 Reset mid-packet SHALL abandon the packet; the requester sees no further ack for it.

Verification
REQ-033 lc_req and hp_req asserted together, lc packet of 3 words (last on word 3) -> lc_ack on 3 consecutive cycles, raw_active=1 for 3 cycles, then 1 idle word, then hp granted.
REQ-034 hp_req and dp_req held, single-word packets each -> grant order hp, dp, hp, dp, with one IDLE and one GAP cycle between packets.
REQ-035 raw_stall=1 for 4 cycles mid-DP packet with data 0xA5A5A5A5 -> raw_data held at 0xA5A5A5A5, dp_ack=0 for 4 cycles, no word lost or duplicated.
REQ-036 dp_req drops 2 cycles mid-packet -> 2 idle words with raw_active=0, err_underrun high 2 cycles, then the packet resumes in DP.
REQ-037 hp streams 263 words with last=0 -> err_timeout pulses on word 263, state goes GAP then IDLE, and word 264 is not acked.
REQ-038 reset_n=0 for 1 cycle mid-HP packet -> next cycle state=IDLE and raw_active=0; a subsequent lc_req is granted normally.
